// File: rtl/traffic_controller.sv
// rtl/traffic_controller.sv - two-way intersection light controller with walk phase
// Optional walk phase: define TRAFFIC_CONTROLLER_WALK_EN.
module traffic_controller #(
  parameter int TICK_DIV = 1,
  parameter int BASE_DEF = 6,
  parameter int EXT_DEF  = 3,
  parameter int YEL_DEF  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor,
  input  logic       walk_request,
  input  logic       reprogram,
  input  logic [1:0] time_param_selector,
  input  logic [3:0] time_value,
  output logic       Rm,
  output logic       Ym,
  output logic       Gm,
  output logic       Rs,
  output logic       Ys,
  output logic       Gs,
  output logic       W
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    MG1  = 3'd0,
    MG2  = 3'd1,
    MY   = 3'd2,
    WALK = 3'd3,
    SG1  = 3'd4,
    SG2  = 3'd5,
    SY   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    timer_q, timer_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    tbase_q, tbase_d;
  logic [3:0]    text_q, text_d;
  logic [3:0]    tyel_q, tyel_d;
  logic          tick, expire, walk_pending;

`ifdef TRAFFIC_CONTROLLER_WALK_EN
  logic walk_q, walk_d;
  assign walk_pending = walk_q;
`else
  logic unused_walk_request;
  assign unused_walk_request = walk_request;
  assign walk_pending = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MG1;
      timer_q <= 4'(BASE_DEF);
      presc_q <= '0;
      tbase_q <= 4'(BASE_DEF);
      text_q  <= 4'(EXT_DEF);
      tyel_q  <= 4'(YEL_DEF);
`ifdef TRAFFIC_CONTROLLER_WALK_EN
      walk_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      presc_q <= presc_d;
      tbase_q <= tbase_d;
      text_q  <= text_d;
      tyel_q  <= tyel_d;
`ifdef TRAFFIC_CONTROLLER_WALK_EN
      walk_q  <= walk_d;
`endif
    end
  end

  always_comb begin
    tick    = (presc_q == PW'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
    // A remaining count of 0 (programmed zero) expires like 1.
    expire  = tick && (timer_q <= 4'd1);
    state_d = state_q;
    if (expire) begin
      case (state_q)
        MG1:     state_d = sensor ? MY : MG2;
        MG2:     state_d = MY;
        MY:      state_d = walk_pending ? WALK : SG1;
        WALK:    state_d = SG1;
        SG1:     state_d = sensor ? SG2 : SY;
        SG2:     state_d = SY;
        default: state_d = MG1;
      endcase
    end

    timer_d = timer_q;
    if (expire) begin
      case (state_d)
        MY, SY:    timer_d = tyel_q;
        WALK, SG2: timer_d = text_q;
        default:   timer_d = tbase_q;
      endcase
    end else if (tick) begin
      timer_d = timer_q - 4'd1;
    end

    tbase_d = tbase_q;
    text_d  = text_q;
    tyel_d  = tyel_q;
    if (reprogram) begin
      case (time_param_selector)
        2'b00:   tbase_d = time_value;
        2'b01:   text_d  = time_value;
        2'b10:   tyel_d  = time_value;
        default: ;
      endcase
      state_d = MG1;
      timer_d = (time_param_selector == 2'b00) ? time_value : tbase_q;
      presc_d = '0;
    end

`ifdef TRAFFIC_CONTROLLER_WALK_EN
    walk_d = walk_q | walk_request;
    if (state_q != WALK && state_d == WALK) walk_d = 1'b0;
`endif
  end

  always_comb begin
    Rm = 1'b0; Ym = 1'b0; Gm = 1'b0;
    Rs = 1'b0; Ys = 1'b0; Gs = 1'b0;
    W  = 1'b0;
    case (state_q)
      MG1, MG2: begin Gm = 1'b1; Rs = 1'b1; end
      MY:       begin Ym = 1'b1; Rs = 1'b1; end
`ifdef TRAFFIC_CONTROLLER_WALK_EN
      WALK:     begin Rm = 1'b1; Rs = 1'b1; W = 1'b1; end
`endif
      SG1, SG2: begin Rm = 1'b1; Gs = 1'b1; end
      SY:       begin Rm = 1'b1; Ys = 1'b1; end
      default:  begin Gm = 1'b1; Rs = 1'b1; end
    endcase
  end

endmodule

// File: tb/tb_traffic_controller.sv
// tb/tb_traffic_controller.sv - randomized check of traffic_controller against a phase/duration model
module tb_traffic_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sensor = 1'b0;
  logic       walk_request = 1'b0;
  logic       reprogram = 1'b0;
  logic [1:0] sel = 2'b11;
  logic [3:0] val = 4'd0;
  logic       Rm, Ym, Gm, Rs, Ys, Gs, W;

  int checks = 0;
  int failures = 0;

  traffic_controller dut (
    .clk(clk), .reset(reset), .sensor(sensor), .walk_request(walk_request),
    .reprogram(reprogram), .time_param_selector(sel), .time_value(val),
    .Rm(Rm), .Ym(Ym), .Gm(Gm), .Rs(Rs), .Ys(Ys), .Gs(Gs), .W(W)
  );

  always #5 clk = ~clk;

`ifdef TRAFFIC_CONTROLLER_WALK_EN
  localparam bit WALK_ON = 1'b1;
`else
  localparam bit WALK_ON = 1'b0;
`endif

  // phases: 0 MG1, 1 MG2, 2 MY, 3 WALK, 4 SG1, 5 SG2, 6 SY; left counts clock cycles
  int ph, left, wl, base, ext, yel;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int dur(input int p);
    case (p)
      2, 6:    return eff(yel);
      3, 5:    return eff(ext);
      default: return eff(base);
    endcase
  endfunction

  // {Rm,Ym,Gm,Rs,Ys,Gs,W}
  function automatic logic [6:0] lamps(input int p);
    case (p)
      0, 1:    return 7'b0011000;
      2:       return 7'b0101000;
      3:       return 7'b1001001;
      4, 5:    return 7'b1000010;
      default: return 7'b1000100;
    endcase
  endfunction

  function automatic logic [6:0] lv();
    return {Rm, Ym, Gm, Rs, Ys, Gs, W};
  endfunction

  task automatic model_reset();
    base = 6; ext = 3; yel = 2;
    ph = 0; left = base; wl = 0;
  endtask

  task automatic model_edge();
    int nx;
    int wl_n;
    wl_n = (WALK_ON && (wl != 0 || walk_request)) ? 1 : 0;
    if (reprogram) begin
      if (sel == 2'b00) base = val;
      if (sel == 2'b01) ext = val;
      if (sel == 2'b10) yel = val;
      ph = 0;
      left = eff(base);
      wl = wl_n;
      return;
    end
    left--;
    if (left == 0) begin
      case (ph)
        0:       nx = sensor ? 2 : 1;
        1:       nx = 2;
        2:       nx = (wl != 0) ? 3 : 4;
        3:       nx = 4;
        4:       nx = sensor ? 5 : 6;
        5:       nx = 6;
        default: nx = 0;
      endcase
      if (nx == 3) wl_n = 0;
      ph = nx;
      left = dur(nx);
    end
    wl = wl_n;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("lamps", lv(), lamps(ph));
  endtask

  task automatic run_len(input int idx, output int n);
    logic [6:0] v;
    n = 0;
    v = lv();
    while (v[idx] && n < 200) begin
      n++;
      step();
      v = lv();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("reset_lamps", lv(), 7'b0011000);
  endtask

  int n;

  initial begin
    model_reset();
    do_reset();

    sensor = 1'b0;
    run_len(4, n); check("mg_len_s0", n, 12);
    run_len(5, n); check("my_len_s0", n, 2);
    run_len(1, n); check("sg_len_s0", n, 6);
    run_len(2, n); check("sy_len_s0", n, 2);
    run_len(4, n); check("mg_period_s0", n, 12);

    sensor = 1'b1;
    run_len(5, n);
    run_len(1, n); check("sg_len_s1", n, 9);
    run_len(2, n); check("sy_len_s1", n, 2);
    run_len(4, n); check("mg_len_s1", n, 6);
    run_len(5, n); check("my_len_s1", n, 2);

    for (int i = 0; i < 7; i++) step();
    check("in_sg2", lv(), 7'b1000010);
    #2 reset = 1'b1;
    #1 check("async_reset", lv(), 7'b0011000);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    sensor = 1'b0;
    run_len(4, n); check("mg_after_reset", n, 12);

    run_len(5, n); run_len(1, n); run_len(2, n);
    walk_request = 1'b1;
    step();
    walk_request = 1'b0;
    run_len(4, n); check("mg_walk", n, 11);
    run_len(5, n); check("my_walk", n, 2);
    run_len(0, n); check("walk_len", n, WALK_ON ? 3 : 0);
    run_len(1, n); check("sg_after_walk", n, 6);
    run_len(2, n);
    run_len(4, n); check("mg_next", n, 12);
    run_len(5, n);
    run_len(0, n); check("no_second_walk", n, 0);
    run_len(1, n); check("sg_next", n, 6);
    run_len(2, n);

    step(); step();
    reprogram = 1'b1; sel = 2'b00; val = 4'd4;
    step();
    reprogram = 1'b0;
    run_len(4, n); check("mg_base4", n, 8);
    run_len(5, n); check("my_base4", n, 2);
    run_len(1, n); check("sg_base4", n, 4);
    run_len(2, n);
    step(); step(); step();
    reprogram = 1'b1; sel = 2'b11; val = 4'd9;
    step();
    reprogram = 1'b0;
    run_len(4, n); check("mg_sel11", n, 8);
    run_len(5, n); check("my_sel11", n, 2);

    reprogram = 1'b1; sel = 2'b00; val = 4'd6;
    for (int i = 0; i < 20; i++) step();
    reprogram = 1'b0;
    check("held_mg1", lv(), 7'b0011000);
    run_len(4, n); check("mg_restored", n, 12);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) sensor = ~sensor;
      walk_request = ($urandom_range(29) == 0);
      reprogram = ($urandom_range(149) == 0);
      sel = 2'($urandom_range(3));
      val = 4'($urandom_range(15));
      step();
    end
    reprogram = 1'b0;
    walk_request = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
